brush_stamp_ctrl: RTL and testbench

//  Sequences the single framebuffer write port for the drawing canvas. Consumes cursor

---
 rtl/brush_stamp_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_brush_stamp_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brush_stamp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : brush_stamp_ctrl
// Description : Sequences the single framebuffer write port of the drawing
//               canvas. While the pen is down it stamps a (2w+1)x(2w+1) brush
//               around the cursor, one pixel slot per accepted cycle, with
//               out-of-canvas slots clipped. A latched clear request sweeps
//               the whole framebuffer with CLEAR_COLOR. The framebuffer
//               writes use a valid/ready handshake.
//               Optional feature macro: ROUND_BRUSH_EN (circular brush mask).
// Revision    : 1.0 - initial release
// ============================================================================
module brush_stamp_ctrl #(
   parameter int         H_RES       = 640,
   parameter int         V_RES       = 360,
   parameter int         ADDR_W      = 18,
   parameter logic [3:0] CLEAR_COLOR = 4'd0
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [9:0]        cursor_x_in,
   input  logic [8:0]        cursor_y_in,
   input  logic [3:0]        color_in,
   input  logic [2:0]        width_in,
   input  logic              pen_down_in,
   input  logic              clear_in,
   input  logic              fb_ready_in,
   output logic [ADDR_W-1:0] fb_addr_out,
   output logic [3:0]        fb_data_out,
   output logic              fb_we_out,
   output logic              busy_out,
   output logic              clear_done_out
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_STAMP = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] C_H_RES     = ADDR_W'(H_RES);
   localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
   localparam logic [9:0]        C_X_LIM     = 10'(H_RES);
   localparam logic [9:0]        C_Y_LIM     = 10'(V_RES);

   // Evaluates one brush slot: returns {write_enable, pixel_address}.
   // Coordinates are extended to signed 11 bits so negative offsets clip.
   function automatic logic [ADDR_W:0] slot_eval(
      input logic [9:0]        x,
      input logic [8:0]        y,
      input logic signed [3:0] dx,
      input logic signed [3:0] dy,
      input logic              hit
   );
      logic signed [10:0] px;
      logic signed [10:0] py;
      logic               in_bounds;
      logic [ADDR_W-1:0]  addr;
      px        = $signed({1'b0, x}) + $signed({{7{dx[3]}}, dx});
      py        = $signed({2'b00, y}) + $signed({{7{dy[3]}}, dy});
      in_bounds = !px[10] && (px[9:0] < C_X_LIM) && !py[10] && (py[9:0] < C_Y_LIM);
      addr      = ADDR_W'(py[9:0]) * C_H_RES + ADDR_W'(px[9:0]);
      return {in_bounds & hit, addr};
   endfunction

`ifdef ROUND_BRUSH_EN
   // Circular mask: slot is inside the brush when dx^2 + dy^2 <= w^2.
   function automatic logic round_hit(
      input logic signed [3:0] dx,
      input logic signed [3:0] dy,
      input logic [2:0]        w
   );
      logic [2:0] ax;
      logic [2:0] ay;
      logic [6:0] r2;
      logic [6:0] w2;
      ax = dx[3] ? 3'(-dx) : dx[2:0];
      ay = dy[3] ? 3'(-dy) : dy[2:0];
      r2 = 7'(ax) * 7'(ax) + 7'(ay) * 7'(ay);
      w2 = 7'(w) * 7'(w);
      return r2 <= w2;
   endfunction
`endif

   state_t            state_q, state_d;
   logic              clear_prev_q, clear_prev_d;
   logic              clear_pend_q, clear_pend_d;
   logic              last_valid_q, last_valid_d;
   logic [9:0]        snap_x_q, snap_x_d;
   logic [8:0]        snap_y_q, snap_y_d;
   logic [3:0]        snap_color_q, snap_color_d;
   logic [2:0]        snap_w_q, snap_w_d;
   logic [9:0]        last_x_q, last_x_d;
   logic [8:0]        last_y_q, last_y_d;
   logic [3:0]        last_color_q, last_color_d;
   logic [2:0]        last_w_q, last_w_d;
   logic signed [3:0] dx_q, dx_d;
   logic signed [3:0] dy_q, dy_d;
   logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
   logic [3:0]        fb_data_q, fb_data_d;
   logic              fb_we_q, fb_we_d;
   logic              busy_q, busy_d;
   logic              clear_done_q, clear_done_d;

   logic              w_clear_edge;
   logic              w_inputs_changed;
   logic              w_trigger;
   logic signed [3:0] w_neg_in_w;
   logic signed [3:0] w_snap_w_s;
   logic signed [3:0] w_neg_snap_w;
   logic              w_last_col;
   logic              w_last_slot;
   logic signed [3:0] w_nxt_dx;
   logic signed [3:0] w_nxt_dy;
   logic              w_first_hit;
   logic              w_next_hit;
   logic [ADDR_W:0]   w_first_slot;
   logic [ADDR_W:0]   w_next_slot;

   // Trigger detection and slot iteration helpers (first slot from live inputs, next slot from snapshot).
   always_comb begin
      w_clear_edge     = clear_in & ~clear_prev_q;
      w_inputs_changed = (cursor_x_in != last_x_q) || (cursor_y_in != last_y_q) ||
                         (color_in != last_color_q) || (width_in != last_w_q);
      w_trigger        = pen_down_in && (!last_valid_q || w_inputs_changed);
      w_neg_in_w       = -$signed({1'b0, width_in});
      w_snap_w_s       = $signed({1'b0, snap_w_q});
      w_neg_snap_w     = -w_snap_w_s;
      w_last_col       = (dx_q == w_snap_w_s);
      w_last_slot      = w_last_col && (dy_q == w_snap_w_s);
      w_nxt_dx         = w_last_col ? w_neg_snap_w : dx_q + 4'sd1;
      w_nxt_dy         = w_last_col ? dy_q + 4'sd1 : dy_q;
`ifdef ROUND_BRUSH_EN
      w_first_hit      = round_hit(w_neg_in_w, w_neg_in_w, width_in);
      w_next_hit       = round_hit(w_nxt_dx, w_nxt_dy, snap_w_q);
`else
      w_first_hit      = 1'b1;
      w_next_hit       = 1'b1;
`endif
      w_first_slot     = slot_eval(cursor_x_in, cursor_y_in, w_neg_in_w, w_neg_in_w, w_first_hit);
      w_next_slot      = slot_eval(snap_x_q, snap_y_q, w_nxt_dx, w_nxt_dy, w_next_hit);
   end

   // Next-state logic; outputs are computed for the cycle after the transition.
   always_comb begin
      state_d      = state_q;
      clear_prev_d = clear_in;
      clear_pend_d = clear_pend_q;
      last_valid_d = last_valid_q;
      snap_x_d     = snap_x_q;
      snap_y_d     = snap_y_q;
      snap_color_d = snap_color_q;
      snap_w_d     = snap_w_q;
      last_x_d     = last_x_q;
      last_y_d     = last_y_q;
      last_color_d = last_color_q;
      last_w_d     = last_w_q;
      dx_d         = dx_q;
      dy_d         = dy_q;
      fb_addr_d    = fb_addr_q;
      fb_data_d    = fb_data_q;
      fb_we_d      = fb_we_q;
      busy_d       = busy_q;
      clear_done_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (w_clear_edge) begin
               clear_pend_d = 1'b1;
            end
            if (!pen_down_in) begin
               last_valid_d = 1'b0;
            end
            if (clear_pend_q) begin
               // Pending clear wins; any edge seen this cycle is folded into it.
               clear_pend_d = 1'b0;
               state_d      = ST_CLEAR;
               fb_addr_d    = '0;
               fb_data_d    = CLEAR_COLOR;
               fb_we_d      = 1'b1;
               busy_d       = 1'b1;
            end else if (w_trigger) begin
               state_d      = ST_STAMP;
               snap_x_d     = cursor_x_in;
               snap_y_d     = cursor_y_in;
               snap_color_d = color_in;
               snap_w_d     = width_in;
               dx_d         = w_neg_in_w;
               dy_d         = w_neg_in_w;
               fb_we_d      = w_first_slot[ADDR_W];
               fb_addr_d    = w_first_slot[ADDR_W-1:0];
               fb_data_d    = color_in;
               busy_d       = 1'b1;
            end else begin
               fb_we_d      = 1'b0;
               busy_d       = 1'b0;
            end
         end

         ST_STAMP: begin
            if (w_clear_edge) begin
               clear_pend_d = 1'b1;
            end
            // A clipped/masked slot (we=0) always advances; a write advances when accepted.
            if (!fb_we_q || fb_ready_in) begin
               if (w_last_slot) begin
                  state_d      = ST_IDLE;
                  last_x_d     = snap_x_q;
                  last_y_d     = snap_y_q;
                  last_color_d = snap_color_q;
                  last_w_d     = snap_w_q;
                  last_valid_d = 1'b1;
                  fb_we_d      = 1'b0;
                  fb_addr_d    = '0;
                  fb_data_d    = '0;
                  busy_d       = 1'b0;
               end else begin
                  dx_d         = w_nxt_dx;
                  dy_d         = w_nxt_dy;
                  fb_we_d      = w_next_slot[ADDR_W];
                  fb_addr_d    = w_next_slot[ADDR_W-1:0];
               end
            end
         end

         ST_CLEAR: begin
            // Clear edges arriving during the sweep are absorbed.
            if (fb_ready_in) begin
               if (fb_addr_q == C_LAST_ADDR) begin
                  state_d      = ST_IDLE;
                  clear_done_d = 1'b1;
                  last_valid_d = 1'b0;
                  fb_we_d      = 1'b0;
                  fb_addr_d    = '0;
                  fb_data_d    = '0;
                  busy_d       = 1'b0;
               end else begin
                  fb_addr_d    = fb_addr_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            fb_we_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= ST_IDLE;
         clear_prev_q <= 1'b0;
         clear_pend_q <= 1'b0;
         last_valid_q <= 1'b0;
         snap_x_q     <= '0;
         snap_y_q     <= '0;
         snap_color_q <= '0;
         snap_w_q     <= '0;
         last_x_q     <= '0;
         last_y_q     <= '0;
         last_color_q <= '0;
         last_w_q     <= '0;
         dx_q         <= '0;
         dy_q         <= '0;
         fb_addr_q    <= '0;
         fb_data_q    <= '0;
         fb_we_q      <= 1'b0;
         busy_q       <= 1'b0;
         clear_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         clear_prev_q <= clear_prev_d;
         clear_pend_q <= clear_pend_d;
         last_valid_q <= last_valid_d;
         snap_x_q     <= snap_x_d;
         snap_y_q     <= snap_y_d;
         snap_color_q <= snap_color_d;
         snap_w_q     <= snap_w_d;
         last_x_q     <= last_x_d;
         last_y_q     <= last_y_d;
         last_color_q <= last_color_d;
         last_w_q     <= last_w_d;
         dx_q         <= dx_d;
         dy_q         <= dy_d;
         fb_addr_q    <= fb_addr_d;
         fb_data_q    <= fb_data_d;
         fb_we_q      <= fb_we_d;
         busy_q       <= busy_d;
         clear_done_q <= clear_done_d;
      end
   end

   assign fb_addr_out    = fb_addr_q;
   assign fb_data_out    = fb_data_q;
   assign fb_we_out      = fb_we_q;
   assign busy_out       = busy_q;
   assign clear_done_out = clear_done_q;

endmodule
`default_nettype wire

// File: tb/tb_brush_stamp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_brush_stamp_ctrl
// Description : Self-checking bench for brush_stamp_ctrl on a reduced 64x48
//               canvas. Table-driven stamp vectors plus directed sequences
//               for back-pressure, clear-during-stamp and reset-mid-clear.
//               Expectations follow ROUND_BRUSH_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_brush_stamp_ctrl;

   localparam int H  = 64;
   localparam int V  = 48;
   localparam int AW = 18;

   logic          clk = 1'b0;
   logic          rst;
   logic [9:0]    cx;
   logic [8:0]    cy;
   logic [3:0]    col;
   logic [2:0]    wid;
   logic          pen;
   logic          clr;
   logic          rdy;
   logic [AW-1:0] addr;
   logic [3:0]    data;
   logic          we;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   brush_stamp_ctrl #(
      .H_RES      (H),
      .V_RES      (V),
      .ADDR_W     (AW),
      .CLEAR_COLOR(4'd0)
   ) dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .cursor_x_in   (cx),
      .cursor_y_in   (cy),
      .color_in      (col),
      .width_in      (wid),
      .pen_down_in   (pen),
      .clear_in      (clr),
      .fb_ready_in   (rdy),
      .fb_addr_out   (addr),
      .fb_data_out   (data),
      .fb_we_out     (we),
      .busy_out      (busy),
      .clear_done_out(done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int x;
      int y;
      int c;
      int w;
      int exp_cycles;
      int exp_writes;
      int exp_first;
      int exp_last;
      int exp_sum;
   } vec_t;

   vec_t vecs[5];

   // Pen up for one cycle (forgets last stamp), then pen down with new inputs; measure the stamp.
   task automatic run_vec(input vec_t v, input int idx);
      int cycles   = 0;
      int writes   = 0;
      int first    = -1;
      int last     = -1;
      int sum      = 0;
      int data_bad = 0;
      bit started  = 0;
      bit fin      = 0;
      @(posedge clk); #1;
      pen = 1'b0;
      @(posedge clk); #1;
      cx  = 10'(v.x);
      cy  = 9'(v.y);
      col = 4'(v.c);
      wid = 3'(v.w);
      pen = 1'b1;
      for (int i = 0; i < 400 && !fin; i++) begin
         @(negedge clk);
         if (busy) begin
            started = 1;
            cycles++;
            if (we && rdy) begin
               writes++;
               if (first < 0) first = int'(addr);
               last = int'(addr);
               sum += int'(addr);
               if (data != 4'(v.c)) data_bad++;
            end
         end else if (started) begin
            fin = 1;
         end
      end
      check($sformatf("v%0d_finished", idx), int'(fin), 1);
      check($sformatf("v%0d_slot_cycles", idx), cycles, v.exp_cycles);
      check($sformatf("v%0d_writes", idx), writes, v.exp_writes);
      check($sformatf("v%0d_first_addr", idx), first, v.exp_first);
      check($sformatf("v%0d_last_addr", idx), last, v.exp_last);
      check($sformatf("v%0d_addr_sum", idx), sum, v.exp_sum);
      check($sformatf("v%0d_bad_data", idx), data_bad, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      int stamp1;
      int stamp2;
      int clr_cnt;
      int addr_err;
      int done_cnt;
      int phase;
      bit pulsed1;
      bit pulsed2;
      bit fin;

      // Table: {x, y, colour, w, slot cycles, writes, first addr, last addr, addr sum}
      vecs[0] = '{32, 24, 5, 0, 1, 1, 1568, 1568, 1568};
`ifdef ROUND_BRUSH_EN
      vecs[1] = '{0, 0, 3, 1, 9, 3, 0, 64, 65};
      vecs[2] = '{63, 47, 9, 1, 9, 3, 3007, 3071, 9148};
      vecs[3] = '{10, 10, 7, 2, 25, 13, 522, 778, 8450};
      vecs[4] = '{32, 24, 12, 7, 225, 149, 1120, 2016, 233632};
`else
      vecs[1] = '{0, 0, 3, 1, 9, 4, 0, 65, 130};
      vecs[2] = '{63, 47, 9, 1, 9, 4, 3006, 3071, 12154};
      vecs[3] = '{10, 10, 7, 2, 25, 25, 520, 780, 16250};
      vecs[4] = '{32, 24, 12, 7, 225, 225, 1113, 2023, 352800};
`endif

      rst = 1'b1; cx = '0; cy = '0; col = '0; wid = '0;
      pen = 1'b0; clr = 1'b0; rdy = 1'b1;

      // Reset held three cycles
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_we", int'(we), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_addr", int'(addr), 0);
      check("rst_data", int'(data), 0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

      // Constant inputs with pen held down: no further stamping
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (we || busy) cnt++;
      end
      check("no_restamp_constant", cnt, 0);

      // Back-pressure: w=0 stamp held while fb_ready_in is low
      @(posedge clk); #1;
      pen = 1'b0; rdy = 1'b0;
      @(posedge clk); #1;
      cx = 10'd20; cy = 9'd20; col = 4'd6; wid = 3'd0; pen = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("hold%0d_we", i), int'(we), 1);
         check($sformatf("hold%0d_addr", i), int'(addr), 1300);
         check($sformatf("hold%0d_data", i), int'(data), 6);
      end
      @(posedge clk); #1;
      rdy = 1'b1;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (we && rdy) cnt++;
      end
      check("hold_written_once", cnt, 1);

      // Clear pulse during a w=7 stamp, second pulse during the sweep is absorbed
      @(negedge clk);
      pen = 1'b0;
      @(negedge clk);
      cx = 10'd32; cy = 9'd24; col = 4'd2; wid = 3'd7; pen = 1'b1;
      stamp1 = 0; stamp2 = 0; clr_cnt = 0; addr_err = 0; done_cnt = 0;
      phase = 0; pulsed1 = 0; pulsed2 = 0; fin = 0;
      for (int i = 0; i < 8000 && !fin; i++) begin
         @(negedge clk);
         clr = 1'b0;
         if (done) begin
            done_cnt++;
            phase = 2;
         end
         if (we && rdy) begin
            if (data == 4'd2) begin
               if (phase == 0) stamp1++;
               else stamp2++;
            end else if (data == 4'd0) begin
               if (int'(addr) != clr_cnt) addr_err++;
               clr_cnt++;
               if (phase == 0) phase = 1;
            end
         end
         if (phase == 2 && stamp2 == 225 && !busy) fin = 1;
         if (!pulsed1 && stamp1 == 10) begin
            clr = 1'b1;
            pulsed1 = 1;
         end
         if (!pulsed2 && clr_cnt == 100) begin
            clr = 1'b1;
            pulsed2 = 1;
         end
      end
      clr = 1'b0;
      check("clr_seq_finished", int'(fin), 1);
      check("clr_stamp_before", stamp1, 225);
      check("clr_sweep_writes", clr_cnt, H * V);
      check("clr_addr_order_errors", addr_err, 0);
      check("clr_done_pulses", done_cnt, 1);
      check("clr_restamp_writes", stamp2, 225);
      pen = 1'b0;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy || we || done) cnt++;
      end
      check("clr_no_reclear", cnt, 0);

      // Reset in the middle of a clear sweep
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      clr_cnt = 0;
      for (int i = 0; i < 200 && clr_cnt < 50; i++) begin
         @(negedge clk);
         if (we && rdy && data == 4'd0) clr_cnt++;
      end
      check("rstclr_started", clr_cnt, 50);
      rst = 1'b1;
      @(negedge clk);
      check("rstclr_we", int'(we), 0);
      check("rstclr_busy", int'(busy), 0);
      check("rstclr_done", int'(done), 0);
      cnt = 0;
      repeat (2) begin
         @(negedge clk);
         if (done || we || busy) cnt++;
      end
      rst = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done || we || busy) cnt++;
      end
      check("rstclr_quiet_after", cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
